// File: rtl/adder_arbiter.sv
// Two-port add/subtract service sharing a single WIDTH-bit adder.
// Subtraction takes two passes through the adder (negate, then add); one operation is in flight at a time.
module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_ovf,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_ovf,
  output logic             busy
);

  // state | meaning
  // IDLE  | arbitrate and accept one request
  // NEG   | tmp <= ~b + 1 (subtract only)
  // ADD   | result <= a + (b or tmp), deliver to requester id_q
  typedef enum logic [1:0] {IDLE, NEG, ADD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, tmp;
  logic             sub_q, id_q, last_grant;
  logic [WIDTH-1:0] add_x, add_y, add_s;
  logic             elig0, elig1, grant0, grant1;
  logic             ovf;

  assign add_s = add_x + add_y;

  assign elig0 = req0_valid && !rsp0_valid;
  assign elig1 = req1_valid && !rsp1_valid;

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    add_x     = '0;
    add_y     = '0;
    case (state)
      IDLE: begin
        if (elig0 && elig1) begin
          grant0 = last_grant;
          grant1 = !last_grant;
        end else begin
          grant0 = elig0;
          grant1 = elig1;
        end
        if (grant0)      state_nxt = req0_sub ? NEG : ADD;
        else if (grant1) state_nxt = req1_sub ? NEG : ADD;
      end
      NEG: begin
        add_x     = ~b_q;
        add_y     = {{(WIDTH-1){1'b0}}, 1'b1};
        state_nxt = ADD;
      end
      ADD: begin
        add_x     = a_q;
        add_y     = sub_q ? tmp : b_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sign rule works on the original b, so b = -2^(WIDTH-1) on subtract still flags correctly.
  assign ovf = sub_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]))
                     : ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]));

  assign req0_ready = rst_n && grant0;
  assign req1_ready = rst_n && grant1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      id_q       <= 1'b0;
      tmp        <= '0;
      last_grant <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp0_sum   <= '0;
      rsp0_ovf   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_sum   <= '0;
      rsp1_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant0 || grant1) begin
        a_q        <= grant1 ? req1_a : req0_a;
        b_q        <= grant1 ? req1_b : req0_b;
        sub_q      <= grant1 ? req1_sub : req0_sub;
        id_q       <= grant1;
        last_grant <= grant1;
      end
      if (state == NEG) tmp <= add_s;
      if (rsp0_valid && rsp0_ready) rsp0_valid <= 1'b0;
      if (rsp1_valid && rsp1_ready) rsp1_valid <= 1'b0;
      if (state == ADD) begin
        if (!id_q) begin
          rsp0_valid <= 1'b1;
          rsp0_sum   <= add_s;
          rsp0_ovf   <= ovf;
        end else begin
          rsp1_valid <= 1'b1;
          rsp1_sum   <= add_s;
          rsp1_ovf   <= ovf;
        end
      end
    end
  end

endmodule
